// File: rtl/hazard_pkg.sv
// Shared types and widths for the hazard stall/flush controller.
package hazard_pkg;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned WaitCntW  = 8;
    localparam int unsigned FlushCntW = 3;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StFlush   = 2'b10
    } state_e;

    // Forwarding cannot cover a load whose result is consumed by the very next instruction.
    function automatic logic load_use_hazard(
        input logic [RegAddrW-1:0] addr1,
        input logic [RegAddrW-1:0] addr2,
        input logic [RegAddrW-1:0] addr_ex,
        input logic                read1,
        input logic                read2,
        input logic                write_ex,
        input logic                load_ex
    );
        return write_ex & load_ex &
               (((addr_ex == addr1) & read1) | ((addr_ex == addr2) & read2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous load and asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             en,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use stalls, memory-busy freeze with timeout, branch squash.
// Optional statistics outputs are enabled by defining HAZARD_STATS_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RegAddrW-1:0] regfile_addr1,
    input  logic [RegAddrW-1:0] regfile_addr2,
    input  logic                reg_read1_ID,
    input  logic                reg_read2_ID,
    input  logic [RegAddrW-1:0] reg_addr_EX,
    input  logic                reg_write_EX,
    input  logic                MemtoReg_EX,
    input  logic                branch_taken_EX,
    input  logic                mem_busy,
    output logic                PC_write,
    output logic                IFID_write,
    output logic                IDEX_write,
    output logic                EXMEM_write,
    output logic                IFID_flush,
    output logic                IDEX_bubble,
    output logic                mem_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [15:0]         flush_events
`endif
);

    localparam logic [FlushCntW-1:0] FlushLoad  = FlushCntW'(FLUSH_CYCLES - 1);
    localparam logic [WaitCntW-1:0]  TimeoutVal = WaitCntW'(MEM_TIMEOUT);

    state_e                 state_q, state_d;
    logic [FlushCntW-1:0]   flush_cnt_q, flush_cnt_d;
    logic                   timeout_q, timeout_set;
    logic [WaitCntW-1:0]    wait_cnt;
    logic                   wait_load, wait_en;
    logic                   load_use;
    logic                   svc, svc_busy;
    logic                   branch_entry;
    logic                   pc_we, ifid_we, idex_we, exmem_we, flush, bubble;

    assign load_use = load_use_hazard(regfile_addr1, regfile_addr2, reg_addr_EX,
                                      reg_read1_ID, reg_read2_ID, reg_write_EX, MemtoReg_EX);

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        timeout_set  = 1'b0;
        wait_load    = 1'b0;
        wait_en      = 1'b0;
        svc          = 1'b0;
        svc_busy     = 1'b0;
        branch_entry = 1'b0;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        flush        = 1'b0;
        bubble       = 1'b0;

        unique case (state_q)
            StRun: begin
                svc      = 1'b1;
                svc_busy = mem_busy;
            end
            StMemWait: begin
                if (!mem_busy) begin
                    svc     = 1'b1;
                    state_d = StRun;
                end else if (wait_cnt >= TimeoutVal) begin
                    // Give up waiting: flag the error and let the pipeline move again.
                    timeout_set = 1'b1;
                    svc         = 1'b1;
                    state_d     = StRun;
                end else begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                    wait_en  = 1'b1;
                end
            end
            StFlush: begin
                if (mem_busy) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                end else begin
                    flush       = 1'b1;
                    bubble      = 1'b1;
                    flush_cnt_d = flush_cnt_q - FlushCntW'(1);
                    if (flush_cnt_q <= FlushCntW'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StRun;
        endcase

        // RUN priority: memory freeze, then taken branch, then load-use stall.
        if (svc) begin
            if (svc_busy) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_we   = 1'b0;
                exmem_we  = 1'b0;
                wait_load = 1'b1;
                state_d   = StMemWait;
            end else if (branch_taken_EX) begin
                flush        = 1'b1;
                bubble       = 1'b1;
                branch_entry = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    flush_cnt_d = FlushLoad;
                    state_d     = StFlush;
                end
            end else if (load_use) begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                bubble  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_q | timeout_set;
        end
    end

    sat_counter #(
        .Width(WaitCntW)
    ) u_wait_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (wait_load),
        .load_value(WaitCntW'(1)),
        .en        (wait_en),
        .count     (wait_cnt)
    );

    // Outputs are forced low while reset is held, independent of the register state.
    assign PC_write    = rst_n & pc_we;
    assign IFID_write  = rst_n & ifid_we;
    assign IDEX_write  = rst_n & idex_we;
    assign EXMEM_write = rst_n & exmem_we;
    assign IFID_flush  = rst_n & flush;
    assign IDEX_bubble = rst_n & bubble;
    assign mem_timeout = rst_n & (timeout_q | timeout_set);

`ifdef HAZARD_STATS_EN
    sat_counter #(
        .Width(32)
    ) u_stall_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_value(32'd0),
        .en        (~PC_write),
        .count     (stall_cycles)
    );

    sat_counter #(
        .Width(16)
    ) u_flush_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_value(16'd0),
        .en        (branch_entry),
        .count     (flush_events)
    );
`else
    logic unused_branch_entry;
    assign unused_branch_entry = branch_entry;
`endif

endmodule
